// File: rtl/fir_pkg.sv
// fir_pkg: shared constants and helpers for the FIR decimator front end.
//   CHANNELS_DEF / DATA_WIDTH_DEF : default lane count and sample width
//   DROP_CNT_W                    : width of the dropped-frame counter
//   pack_state_e                  : framing state of the channel packer
//   lane_lsb()                    : LSB position of a lane inside a beat
package fir_pkg;

    localparam int unsigned CHANNELS_DEF   = 16;
    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned DROP_CNT_W     = 16;

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } pack_state_e;

    // Lane ch of a beat occupies [lane_lsb(ch, dw) +: dw].
    function automatic int unsigned lane_lsb(input int unsigned ch, input int unsigned dw);
        return ch * dw;
    endfunction

endpackage

// File: rtl/axis_frame_fifo.sv
// axis_frame_fifo: small frame FIFO that owns the AXI-Stream output registers.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write request and frame
//   full_o        : all DEPTH entries occupied (before this cycle's pop)
//   ready_i       : downstream ready; a pop happens on valid_o && ready_i
//   valid_o/data_o: head entry, registered (valid_o never depends on ready_i)
// A push while full still lands when the head is popped in the same cycle;
// otherwise it is ignored and the caller accounts for the drop.
module axis_frame_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 256
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int unsigned CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             pop;
    logic             push_ok;

    assign valid_o = (cnt_q != '0);
    assign full_o  = (cnt_q == CNTW'(DEPTH));
    assign data_o  = mem_q[0];
    assign pop     = valid_o && ready_i;
    assign push_ok = push_i && (!full_o || pop);

    // Entry 0 is always the head, so a pop shifts the array down and the
    // incoming frame is written at the post-pop occupancy.
    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (pop) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
            cnt_d = cnt_q - CNTW'(1);
        end
        if (push_ok) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (CNTW'(i) == cnt_d) begin
                    mem_d[i] = data_i;
                end
            end
            cnt_d = cnt_d + CNTW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/chan_avg_packer.sv
// chan_avg_packer: accumulates AVG consecutive channel-interleaved frames and
// emits each averaged frame as one CHANNELS*DATA_WIDTH AXI-Stream beat.
//   clk, nrst         : clock, asynchronous active-low reset
//   in_valid/in_ch/in_data : non-stallable sample stream, one sample per cycle
//   m_tvalid/m_tready/m_tdata : AXIS master, lane ch at [ch*DW +: DW]
//   clr_flags         : synchronous clear of seq_err, overflow, drop_count
//   seq_err           : sticky, channel order violated
//   overflow          : sticky, at least one frame dropped
//   drop_count        : saturating count of dropped frames
module chan_avg_packer
    import fir_pkg::*;
#(
    parameter int unsigned CHANNELS   = CHANNELS_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned AVG        = 4
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           in_valid,
    input  logic [$clog2(CHANNELS)-1:0]    in_ch,
    input  logic [DATA_WIDTH-1:0]          in_data,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic [CHANNELS*DATA_WIDTH-1:0] m_tdata,
    input  logic                           clr_flags,
    output logic                           seq_err,
    output logic                           overflow,
    output logic [DROP_CNT_W-1:0]          drop_count
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned CW = $clog2(CHANNELS);
    localparam int unsigned SH = $clog2(AVG);
    localparam int unsigned AW = DW + SH;
    localparam int unsigned FW = (SH == 0) ? 1 : SH;
    localparam int unsigned LW = CHANNELS * DW;

    pack_state_e state_q, state_d;
    logic [CW-1:0] exp_q, exp_d;
    logic [FW-1:0] fcnt_q, fcnt_d;

    logic signed [AW-1:0] acc_q [CHANNELS];
    logic                 acc_we;
    logic [CW-1:0]        acc_idx;
    logic signed [AW-1:0] acc_wval;

    logic signed [AW-1:0] in_ext;
    logic signed [AW-1:0] acc_sum;
    logic                 in_match;
    logic                 last_ch;
    logic                 last_frame;

    logic                 frame_push;
    logic                 seq_evt;
    logic [LW-1:0]        frame;
    logic                 fifo_full;
    logic                 fifo_drop;

    logic                  seq_err_q, seq_err_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    assign in_ext     = AW'(signed'(in_data));
    assign in_match   = (in_ch == exp_q);
    assign last_ch    = (exp_q == CW'(CHANNELS - 1));
    assign last_frame = (fcnt_q == FW'(AVG - 1));
    // First frame of a window loads the accumulator, later frames add to it.
    assign acc_sum    = (fcnt_q == '0) ? in_ext : (acc_q[exp_q] + in_ext);

    // Framing FSM: channel/frame counters and accumulator write selection.
    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        fcnt_d     = fcnt_q;
        acc_we     = 1'b0;
        acc_idx    = '0;
        acc_wval   = in_ext;
        frame_push = 1'b0;
        seq_evt    = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (in_valid && (in_ch == '0)) begin
                    acc_we   = 1'b1;
                    acc_idx  = '0;
                    acc_wval = in_ext;
                    exp_d    = CW'(1);
                    fcnt_d   = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    if (in_match) begin
                        acc_we   = 1'b1;
                        acc_idx  = exp_q;
                        acc_wval = acc_sum;
                        if (last_ch) begin
                            exp_d = '0;
                            if (last_frame) begin
                                fcnt_d     = '0;
                                frame_push = 1'b1;
                            end else begin
                                fcnt_d = fcnt_q + FW'(1);
                            end
                        end else begin
                            exp_d = exp_q + CW'(1);
                        end
                    end else begin
                        seq_evt = 1'b1;
                        fcnt_d  = '0;
                        if (in_ch == '0) begin
                            // Out-of-order ch0 restarts the window in place.
                            acc_we   = 1'b1;
                            acc_idx  = '0;
                            acc_wval = in_ext;
                            exp_d    = CW'(1);
                        end else begin
                            exp_d   = '0;
                            state_d = ST_SYNC;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    // Averaged beat; the last lane's sample arrives this cycle so it bypasses
    // the accumulator register. >>> floors toward minus infinity.
    always_comb begin
        frame = '0;
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            if (ch == CHANNELS - 1) begin
                frame[lane_lsb(ch, DW) +: DW] = DW'(acc_sum >>> SH);
            end else begin
                frame[lane_lsb(ch, DW) +: DW] = DW'(acc_q[CW'(ch)] >>> SH);
            end
        end
    end

    assign fifo_drop = frame_push && fifo_full && !(m_tvalid && m_tready);

    // Sticky flags: a same-cycle event takes precedence over clr_flags.
    always_comb begin
        seq_err_d  = clr_flags ? 1'b0 : seq_err_q;
        overflow_d = clr_flags ? 1'b0 : overflow_q;
        drop_cnt_d = clr_flags ? '0 : drop_cnt_q;
        if (seq_evt) begin
            seq_err_d = 1'b1;
        end
        if (fifo_drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_d != '1) begin
                drop_cnt_d = drop_cnt_d + DROP_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_SYNC;
            exp_q      <= '0;
            fcnt_q     <= '0;
            seq_err_q  <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            fcnt_q     <= fcnt_d;
            seq_err_q  <= seq_err_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Accumulators are always loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (acc_we) begin
            acc_q[acc_idx] <= acc_wval;
        end
    end

    axis_frame_fifo #(
        .DEPTH (2),
        .WIDTH (LW)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (nrst),
        .push_i  (frame_push),
        .data_i  (frame),
        .full_o  (fifo_full),
        .ready_i (m_tready),
        .valid_o (m_tvalid),
        .data_o  (m_tdata)
    );

    assign seq_err    = seq_err_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_chan_avg_packer.sv
module tb_chan_avg_packer;

    localparam int C   = 16;
    localparam int DW  = 16;
    localparam int AVG = 4;
    localparam int LW  = C * DW;

    logic          clk = 1'b0;
    logic          nrst;
    logic          in_valid;
    logic [3:0]    in_ch;
    logic [DW-1:0] in_data;
    logic          m_tvalid;
    logic          m_tready;
    logic [LW-1:0] m_tdata;
    logic          clr_flags;
    logic          seq_err;
    logic          overflow;
    logic [15:0]   drop_count;

    chan_avg_packer #(
        .CHANNELS   (C),
        .DATA_WIDTH (DW),
        .AVG        (AVG)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .in_valid   (in_valid),
        .in_ch      (in_ch),
        .in_data    (in_data),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .clr_flags  (clr_flags),
        .seq_err    (seq_err),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a window of C*AVG in-order samples, beats in a queue
    // that stands for the two-deep output buffer.
    logic [LW-1:0] exp_q[$];
    bit            m_sync;
    int            m_pos;
    int            win[C*AVG];
    bit            m_seq;
    bit            m_ovf;
    int            m_dc;
    int            delivered;
    logic [LW-1:0] last_beat;
    bit            rnd_ready;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int floor_div(input int s, input int d);
        int q;
        q = s / d;
        if ((s % d) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_sync = 0;
        m_pos  = 0;
        m_seq  = 0;
        m_ovf  = 0;
        m_dc   = 0;
    endtask

    task automatic model_commit();
        logic [LW-1:0] b;
        int            s;
        int            lane;
        logic [DW-1:0] lv;
        b = '0;
        for (int ch = 0; ch < C; ch++) begin
            s = 0;
            for (int f = 0; f < AVG; f++) s += win[f*C + ch];
            lane = floor_div(s, AVG);
            lv = lane[DW-1:0];
            b[ch*DW +: DW] = lv;
        end
        if (exp_q.size() >= 2) begin
            m_ovf = 1;
            if (m_dc < 65535) m_dc++;
        end else begin
            exp_q.push_back(b);
        end
    endtask

    task automatic model_sample(input int ch, input int d);
        if (!m_sync) begin
            if (ch == 0) begin
                m_sync = 1;
                win[0] = d;
                m_pos  = 1;
            end
        end else if (ch == m_pos % C) begin
            win[m_pos] = d;
            m_pos++;
            if (m_pos == C*AVG) begin
                model_commit();
                m_pos = 0;
            end
        end else begin
            m_seq = 1;
            if (ch == 0) begin
                win[0] = d;
                m_pos  = 1;
            end else begin
                m_sync = 0;
                m_pos  = 0;
            end
        end
    endtask

    // One clock: check outputs mid-cycle, advance the model with the inputs
    // that the coming edge will take, then move inputs past that edge.
    task automatic tick();
        @(negedge clk);
        chk("tvalid", m_tvalid, exp_q.size() != 0);
        if (exp_q.size() != 0) chk("tdata", m_tdata, exp_q[0]);
        chk("seq_err", seq_err, m_seq);
        chk("overflow", overflow, m_ovf);
        chk("drop_count", drop_count, 16'(m_dc));
        if (exp_q.size() != 0 && m_tready) begin
            last_beat = exp_q.pop_front();
            delivered++;
        end
        if (clr_flags) begin
            m_seq = 0;
            m_ovf = 0;
            m_dc  = 0;
        end
        if (in_valid) model_sample(int'(in_ch), int'($signed(in_data)));
        @(posedge clk);
        #1;
        if (rnd_ready) m_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input int ch, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_ch    = 4'(ch);
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_frames_rand(input int n);
        for (int f = 0; f < n; f++)
            for (int ch = 0; ch < C; ch++)
                send(ch, 16'($urandom));
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        clr_flags = 1'b0;
        nrst      = 1'b0;
        #1;
        chk("rst_tvalid", m_tvalid, 1'b0);
        chk("rst_seq", seq_err, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_dc", drop_count, 16'd0);
        model_clear();
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int            d0;
        logic [DW-1:0] lv;
        logic [LW-1:0] all100;

        nrst = 1'b0; in_valid = 1'b0; in_ch = '0; in_data = '0;
        m_tready = 1'b1; clr_flags = 1'b0; rnd_ready = 0;
        delivered = 0; last_beat = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("init_tvalid", m_tvalid, 1'b0);
        chk("init_tdata", m_tdata, '0);
        chk("init_seq", seq_err, 1'b0);
        chk("init_ovf", overflow, 1'b0);
        chk("init_dc", drop_count, 16'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;

        // Constant 100 on every lane for four frames.
        for (int f = 0; f < AVG; f++)
            for (int ch = 0; ch < C; ch++)
                send(ch, 16'd100);
        idle(3);
        all100 = {C{16'd100}};
        chk("A_beats", delivered, 1);
        chk("A_lanes", last_beat, all100);

        // Floor on negatives and full-scale positive.
        for (int f = 0; f < AVG; f++)
            for (int ch = 0; ch < C; ch++)
                send(ch, (ch == 0) ? 16'h7FFF : (ch == 3) ? ((f == 3) ? 16'hFFFE : 16'hFFFD) : 16'h0000);
        idle(3);
        chk("B_beats", delivered, 2);
        lv = last_beat[3*DW +: DW];
        chk("B_lane3", lv, 16'hFFFD);
        lv = last_beat[0 +: DW];
        chk("B_lane0", lv, 16'h7FFF);

        // Three commits under back-pressure: two held, one dropped.
        m_tready = 1'b0;
        d0 = delivered;
        send_frames_rand(3 * AVG);
        idle(2);
        chk("C_ovf", overflow, 1'b1);
        chk("C_drop", drop_count, 16'd1);
        chk("C_hold", m_tvalid, 1'b1);
        m_tready = 1'b1;
        idle(4);
        chk("C_deliv", delivered, d0 + 2);

        // Sequence error, resync, flag clear.
        send(0, 16'd5); send(1, 16'd6); send(3, 16'd7);
        chk("D_seq", seq_err, 1'b1);
        d0 = delivered;
        send(1, 16'd9);
        send_frames_rand(AVG);
        idle(2);
        chk("D_deliv", delivered, d0 + 1);
        clr_flags = 1'b1;
        idle(1);
        clr_flags = 1'b0;
        idle(1);
        chk("D_clr_seq", seq_err, 1'b0);
        chk("D_clr_ovf", overflow, 1'b0);
        chk("D_clr_dc", drop_count, 16'd0);
        send(0, 16'd1);
        clr_flags = 1'b1;
        send(2, 16'd9);
        clr_flags = 1'b0;
        idle(1);
        chk("D_clr_vs_evt", seq_err, 1'b1);

        // Reset mid-frame with a beat pending.
        m_tready = 1'b0;
        send_frames_rand(AVG);
        for (int ch = 0; ch < 5; ch++) send(ch, 16'($urandom));
        chk("E_pend", m_tvalid, 1'b1);
        do_reset();
        m_tready = 1'b1;
        d0 = delivered;
        send_frames_rand(AVG - 1);
        idle(3);
        chk("E_none", delivered, d0);
        send_frames_rand(1);
        idle(2);
        chk("E_one", delivered, d0 + 1);

        // Ramp per channel with random gaps and ~50% back-pressure.
        rnd_ready = 1;
        for (int f = 0; f < 1000; f++) begin
            for (int ch = 0; ch < C; ch++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                send(ch, 16'(ch * 4096 + f * 53 + int'($urandom_range(0, 15))));
            end
        end
        rnd_ready = 0;
        m_tready  = 1'b1;
        idle(4);
        chk("R_empty", m_tvalid, 1'b0);
        chk("R_nodrop", drop_count, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
